// File: rtl/write_flash.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : write_flash                                                   |
// | Purpose  : I2C master copying WORD_NUM 16-bit RAM words into a serial     |
// |            EEPROM with page writes, starting at byte address 0x0000.      |
// | Option   : WRITE_FLASH_ACK_POLL_EN replaces the fixed write-cycle wait    |
// |            with device-address ACK polling.                               |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module write_flash #(
    parameter int          ADDR_SZ    = 12,
    parameter int          WORD_NUM   = 'hb00,
    parameter int          BIT_CYC    = 250,
    parameter int          PAGE_WORDS = 16,
    parameter logic [6:0]  DEV_ADDR   = 7'b1010000,
    parameter int          TWR_CYC    = 1250000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_irq,
    input  logic [15:0]        i_flash_data,
    output logic               o_flash_rd_en,
    output logic [ADDR_SZ-1:0] o_flash_raddr,
    output logic               o_scl,
    inout  wire                b_sda,
    output logic               o_flash_write_done,
    output logic               o_flash_err
);

    localparam int IDX_W = ADDR_SZ + 1;

    localparam logic [31:0]      C_HALF     = 32'(BIT_CYC / 2);
    localparam logic [31:0]      C_HALF_M1  = 32'(BIT_CYC / 2 - 1);
    localparam logic [31:0]      C_FALL     = 32'(BIT_CYC - BIT_CYC / 8);
    localparam logic [31:0]      C_SAMPLE   = 32'(3 * BIT_CYC / 4);
    localparam logic [31:0]      C_BIT_M1   = 32'(BIT_CYC - 1);
    localparam logic [31:0]      C_PAGE     = 32'(PAGE_WORDS);
    localparam logic [IDX_W-1:0] C_WORD_NUM = IDX_W'(WORD_NUM);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT     = 4'd1;
    localparam logic [3:0] S_START    = 4'd2;
    localparam logic [3:0] S_DEV_W    = 4'd3;
    localparam logic [3:0] S_ADDR_H   = 4'd4;
    localparam logic [3:0] S_ADDR_L   = 4'd5;
    localparam logic [3:0] S_FETCH    = 4'd6;
    localparam logic [3:0] S_DATA_H   = 4'd7;
    localparam logic [3:0] S_DATA_L   = 4'd8;
    localparam logic [3:0] S_STOP_RDY = 4'd9;
    localparam logic [3:0] S_STOP     = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;
`ifdef WRITE_FLASH_ACK_POLL_EN
    localparam logic [3:0] S_POLL     = 4'd12;
`else
    localparam logic [3:0] S_TWR      = 4'd12;
    localparam logic [31:0] C_TWR_M1  = 32'(TWR_CYC - 1);
`endif

    logic [3:0]         state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [3:0]         slot_q, slot_d;
    logic               ack_q, ack_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [15:0]        data_q, data_d;
    logic [ADDR_SZ-1:0] raddr_q, raddr_d;
    logic               rd_en_q, rd_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               scl_q, scl_d;
    logic               sda_low_q, sda_low_d;
    logic               sda_pin_q;
`ifdef WRITE_FLASH_ACK_POLL_EN
    logic               poll_q, poll_d;
    logic               fin_q, fin_d;
    logic [7:0]         poll_cnt_q, poll_cnt_d;
`endif

    logic               w_in_byte;
    logic               w_byte_end;
    logic [7:0]         w_tx_byte;
    logic               w_tx_bit;
    logic [15:0]        w_byte_addr;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_page_end;

    assign w_in_byte   = (state_q == S_DEV_W) || (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                         (state_q == S_DATA_H) || (state_q == S_DATA_L);
    assign w_byte_end  = w_in_byte && (slot_q == 4'd8) && (cnt_q == C_BIT_M1);
    assign w_byte_addr = 16'({word_idx_q, 1'b0});
    assign w_next_idx  = word_idx_q + 1'b1;
    assign w_page_end  = ((32'(w_next_idx) % C_PAGE) == 32'd0);
    assign w_tx_bit    = w_tx_byte[3'd7 - slot_q[2:0]];

    always_comb begin
        w_tx_byte = 8'hFF;
        case (state_q)
            S_DEV_W:  w_tx_byte = {DEV_ADDR, 1'b0};
            S_ADDR_H: w_tx_byte = w_byte_addr[15:8];
            S_ADDR_L: w_tx_byte = w_byte_addr[7:0];
            S_DATA_H: w_tx_byte = data_q[15:8];
            S_DATA_L: w_tx_byte = data_q[7:0];
            default:  w_tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        slot_d     = slot_q;
        ack_d      = ack_q;
        word_idx_d = word_idx_q;
        data_d     = data_q;
        raddr_d    = raddr_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        scl_d      = 1'b1;
        sda_low_d  = 1'b0;
`ifdef WRITE_FLASH_ACK_POLL_EN
        poll_d     = poll_q;
        fin_d      = fin_q;
        poll_cnt_d = poll_cnt_q;
`endif

        // Shared 9-slot byte engine: 8 data bits MSB first, then the ACK slot.
        if (w_in_byte) begin
            scl_d     = (cnt_q >= C_HALF) && (cnt_q < C_FALL);
            sda_low_d = (slot_q != 4'd8) && !w_tx_bit;
            if ((slot_q == 4'd8) && (cnt_q == C_SAMPLE))
                ack_d = (b_sda == 1'b0);
            if (cnt_q == C_BIT_M1) begin
                cnt_d  = '0;
                slot_d = (slot_q == 4'd8) ? 4'd0 : slot_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                slot_d     = '0;
                word_idx_d = '0;
`ifdef WRITE_FLASH_ACK_POLL_EN
                poll_d     = 1'b0;
                fin_d      = 1'b0;
                poll_cnt_d = '0;
`endif
                if (i_wr_irq) begin
                    state_d = S_INIT;
                    err_d   = 1'b0;
                end
            end
            S_INIT: begin
                if (cnt_q == C_HALF_M1) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                sda_low_d = 1'b1;
                if (cnt_q == C_HALF_M1) begin
                    state_d = S_DEV_W;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
            end
            S_DEV_W: begin
                if (w_byte_end) begin
`ifdef WRITE_FLASH_ACK_POLL_EN
                    if (poll_q) begin
                        if (ack_q) begin
                            poll_d = 1'b0;
                            if (word_idx_q == C_WORD_NUM) begin
                                fin_d   = 1'b1;
                                state_d = S_STOP_RDY;
                            end else begin
                                state_d = S_ADDR_H;
                            end
                        end else begin
                            // A busy EEPROM NACKs polls; only the 255th one is an error.
                            state_d    = S_STOP_RDY;
                            poll_cnt_d = poll_cnt_q + 8'd1;
                            if (poll_cnt_q == 8'd254)
                                err_d = 1'b1;
                        end
                    end else if (ack_q) begin
                        state_d = S_ADDR_H;
                    end else begin
                        state_d = S_STOP_RDY;
                        err_d   = 1'b1;
                    end
`else
                    if (ack_q) begin
                        state_d = S_ADDR_H;
                    end else begin
                        state_d = S_STOP_RDY;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_ADDR_H, S_ADDR_L, S_DATA_H: begin
                if (w_byte_end) begin
                    if (!ack_q) begin
                        state_d = S_STOP_RDY;
                        err_d   = 1'b1;
                    end else if (state_q == S_ADDR_H) begin
                        state_d = S_ADDR_L;
                    end else if (state_q == S_ADDR_L) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DATA_L;
                    end
                end
            end
            S_FETCH: begin
                scl_d = 1'b0;
                if (cnt_q == 32'd0) begin
                    rd_en_d = 1'b1;
                    raddr_d = word_idx_q[ADDR_SZ-1:0];
                end
                // RAM data becomes valid two cycles after the visible strobe.
                if (cnt_q == 32'd3) begin
                    data_d  = i_flash_data;
                    state_d = S_DATA_H;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
            end
            S_DATA_L: begin
                if (w_byte_end) begin
                    if (!ack_q) begin
                        state_d = S_STOP_RDY;
                        err_d   = 1'b1;
                    end else begin
                        word_idx_d = w_next_idx;
                        if ((w_next_idx == C_WORD_NUM) || w_page_end) begin
                            state_d = S_STOP_RDY;
`ifdef WRITE_FLASH_ACK_POLL_EN
                            poll_d     = 1'b1;
                            poll_cnt_d = '0;
`endif
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_STOP_RDY: begin
                scl_d     = 1'b0;
                sda_low_d = 1'b1;
                if (cnt_q == C_HALF_M1) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                sda_low_d = (cnt_q < C_HALF);
                if (cnt_q == C_BIT_M1) begin
                    cnt_d = '0;
`ifdef WRITE_FLASH_ACK_POLL_EN
                    if (err_q)
                        state_d = S_IDLE;
                    else if (fin_q)
                        state_d = S_DONE;
                    else if (poll_q)
                        state_d = S_POLL;
                    else
                        state_d = S_IDLE;
`else
                    state_d = err_q ? S_IDLE : S_TWR;
`endif
                end
            end
`ifdef WRITE_FLASH_ACK_POLL_EN
            S_POLL: begin
                if (cnt_q == C_BIT_M1) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
`else
            S_TWR: begin
                if (cnt_q == C_TWR_M1) begin
                    cnt_d   = '0;
                    state_d = (word_idx_q == C_WORD_NUM) ? S_DONE : S_INIT;
                end
            end
`endif
            S_DONE: begin
                done_d     = 1'b1;
                word_idx_d = '0;
                raddr_d    = '0;
                cnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            slot_q     <= '0;
            ack_q      <= 1'b0;
            word_idx_q <= '0;
            data_q     <= '0;
            raddr_q    <= '0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            sda_pin_q  <= 1'b0;
`ifdef WRITE_FLASH_ACK_POLL_EN
            poll_q     <= 1'b0;
            fin_q      <= 1'b0;
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            ack_q      <= ack_d;
            word_idx_q <= word_idx_d;
            data_q     <= data_d;
            raddr_q    <= raddr_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
            // Extra stage keeps every SDA edge one cycle behind the SCL edge.
            sda_pin_q  <= sda_low_q;
`ifdef WRITE_FLASH_ACK_POLL_EN
            poll_q     <= poll_d;
            fin_q      <= fin_d;
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign b_sda              = sda_pin_q ? 1'b0 : 1'bz;
    assign o_scl              = scl_q;
    assign o_flash_rd_en      = rd_en_q;
    assign o_flash_raddr      = raddr_q;
    assign o_flash_write_done = done_q;
    assign o_flash_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_write_flash.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_write_flash                                                |
// | Purpose  : Self-checking bench for write_flash with an I2C EEPROM model.  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_write_flash;

    localparam int WN  = 20;
    localparam int BC  = 16;
    localparam int PW  = 16;
    localparam int TW  = 100;
    localparam int ASZ = 5;
    localparam int MS  = 256;   // START marker in byte streams
    localparam int MP  = 512;   // STOP marker in byte streams

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           irq = 1'b0;
    logic [15:0]    fdata = '0;
    logic           rd_en;
    logic [ASZ-1:0] raddr;
    logic           scl;
    wire            b_sda;
    logic           done;
    logic           err;
    logic           slv_low = 1'b0;

    pullup (b_sda);
    assign b_sda = slv_low ? 1'b0 : 1'bz;

    write_flash #(
        .ADDR_SZ(ASZ), .WORD_NUM(WN), .BIT_CYC(BC), .PAGE_WORDS(PW),
        .DEV_ADDR(7'b1010000), .TWR_CYC(TW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_irq(irq), .i_flash_data(fdata),
        .o_flash_rd_en(rd_en), .o_flash_raddr(raddr), .o_scl(scl), .b_sda(b_sda),
        .o_flash_write_done(done), .o_flash_err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:31];
    logic [15:0] ram_p1 = '0;
    always @(posedge clk) begin
        if (rd_en) ram_p1 <= ram[raddr];
        fdata <= ram_p1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // EEPROM slave model and bus monitor
    int  cyc = 0;
    int  obs[$];
    int  exp_q[$];
    int  start_t[$];
    int  stop_t[$];
    int  txn_idx = 0, nbytes = 0, bitcnt = 0;
    int  nack_from = 0, nack_num = 0;
    int  rd_cnt = 0, done_cnt = 0, done_t = 0;
    bit  in_txn = 0, ps = 1, pd = 1, prev_rd = 0;
    logic [7:0] sh = '0;

    always @(negedge clk) begin
        logic s, d;
        cyc++;
        if (!rst_n) begin
            slv_low = 1'b0; in_txn = 0; bitcnt = 0; ps = 1; pd = 1; prev_rd = 0;
        end else begin
            s = scl;
            d = (b_sda === 1'b0) ? 1'b0 : 1'b1;
            if (ps && s && pd && !d) begin
                in_txn = 1; bitcnt = 0; nbytes = 0;
                obs.push_back(MS); start_t.push_back(cyc);
            end else if (ps && s && !pd && d) begin
                in_txn = 0; obs.push_back(MP); stop_t.push_back(cyc); txn_idx++;
            end else if (in_txn && !ps && s) begin
                if (bitcnt < 8) sh = {sh[6:0], d};
                bitcnt++;
                if (bitcnt == 8) obs.push_back(int'(sh));
            end else if (in_txn && ps && !s) begin
                if (bitcnt == 8) begin
                    slv_low = !(nbytes == 0 && txn_idx >= nack_from && txn_idx < nack_from + nack_num);
                    nbytes++;
                end else if (bitcnt == 9) begin
                    slv_low = 1'b0; bitcnt = 0;
                end
            end
            ps = s; pd = d;
            if (rd_en) begin
                check("raddr", int'(raddr), rd_cnt);
                check("rd_en_single_cycle", int'(prev_rd), 0);
                rd_cnt++;
            end
            prev_rd = rd_en;
            if (done) begin done_cnt++; done_t = cyc; end
        end
    end

    // Reference stream: what the EEPROM must see, derived from RAM contents.
    function automatic bit nacked(input int t);
        return (t >= nack_from) && (t < nack_from + nack_num);
    endfunction

    task automatic push_page(inout int w);
        int n;
        n = PW - (w % PW);
        if (n > WN - w) n = WN - w;
        exp_q.push_back(((w * 2) >> 8) & 255);
        exp_q.push_back((w * 2) & 255);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(int'(ram[w + i][15:8]));
            exp_q.push_back(int'(ram[w + i][7:0]));
        end
        w += n;
    endtask

    task automatic build_exp();
        int t = 0;
        int w = 0;
        exp_q.delete();
`ifdef WRITE_FLASH_ACK_POLL_EN
        if (nacked(0)) begin
            exp_q.push_back(MS); exp_q.push_back(8'hA0); exp_q.push_back(MP);
            return;
        end
        exp_q.push_back(MS); exp_q.push_back(8'hA0); push_page(w); exp_q.push_back(MP);
        for (int k = 0; k < 300; k++) begin
            t++;
            exp_q.push_back(MS); exp_q.push_back(8'hA0);
            if (nacked(t)) begin
                exp_q.push_back(MP);
            end else if (w < WN) begin
                push_page(w); exp_q.push_back(MP);
            end else begin
                exp_q.push_back(MP);
                break;
            end
        end
`else
        while (w < WN) begin
            exp_q.push_back(MS); exp_q.push_back(8'hA0);
            if (nacked(t)) begin
                exp_q.push_back(MP);
                return;
            end
            push_page(w); exp_q.push_back(MP);
            t++;
        end
`endif
    endtask

    typedef struct {
        int nf;
        int nn;
        bit reirq;
        int exp_err;
        int exp_done;
        int exp_rd;
    } vec_t;

    vec_t tbl [4];

    task automatic run_row(input vec_t v, input string tag);
        int k;
        int nbad;
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
        nack_from = v.nf; nack_num = v.nn;
        txn_idx = 0; rd_cnt = 0; done_cnt = 0;
        obs.delete(); start_t.delete(); stop_t.delete();
        build_exp();
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0;
        if (v.reirq) begin
            k = 0;
            while (rd_cnt < 1 && k < 3000) begin @(negedge clk); k++; end
            check({tag, "_fetch_timeout"}, int'(k >= 3000), 0);
            repeat (10) @(negedge clk);
            irq = 1'b1;
            repeat (5) @(negedge clk);
            irq = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && !err && k < 30000) begin @(negedge clk); k++; end
        check({tag, "_timeout"}, int'(k >= 30000), 0);
        repeat (600) @(negedge clk);
        check({tag, "_err"}, int'(err), v.exp_err);
        check({tag, "_done_count"}, done_cnt, v.exp_done);
        check({tag, "_rd_count"}, rd_cnt, v.exp_rd);
        check({tag, "_stream_len"}, obs.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i] != exp_q[i]) nbad++;
        check({tag, "_stream_mismatches"}, nbad, 0);
`ifndef WRITE_FLASH_ACK_POLL_EN
        if (v.exp_done == 1 && stop_t.size() >= 2 && start_t.size() >= 2) begin
            check({tag, "_twr_gap_ok"}, int'(start_t[1] - stop_t[0] >= TW), 1);
            k = done_t - stop_t[stop_t.size() - 1];
            check({tag, "_done_delay_ok"}, int'(k >= TW && k <= TW + 20), 1);
        end
`endif
    endtask

    initial begin
        int k;
        tbl[0] = '{WN, 0, 1'b0, 0, 1, WN};
        tbl[1] = '{0,  1, 1'b0, 1, 0, 0};
        tbl[2] = '{WN, 0, 1'b1, 0, 1, WN};
`ifdef WRITE_FLASH_ACK_POLL_EN
        tbl[3] = '{1,  3, 1'b0, 0, 1, WN};
`else
        tbl[3] = '{1,  1, 1'b0, 1, 0, PW};
`endif
        for (int i = 0; i < 32; i++) ram[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda", int'(b_sda === 1'b1), 1);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        repeat (50) @(negedge clk);
        check("idle_no_start", start_t.size(), 0);

        for (int i = 0; i < 4; i++) run_row(tbl[i], $sformatf("row%0d", i));

        // Reset in the middle of the second word's low data byte
        nack_from = 0; nack_num = 0; rd_cnt = 0; done_cnt = 0;
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0;
        k = 0;
        while (rd_cnt < 2 && k < 5000) begin @(negedge clk); k++; end
        check("midrst_fetch_timeout", int'(k >= 5000), 0);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_scl", int'(scl), 1);
        check("midrst_sda", int'(b_sda === 1'b1), 1);
        check("midrst_raddr", int'(raddr), 0);
        check("midrst_rd_en", int'(rd_en), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_row(tbl[0], "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
